// File: rtl/alu_exec_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_exec_stage_pkg : op codes, flag indices and FSM states for the stage  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package alu_exec_stage_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_XOR  = 3'd2,
    OP_RED  = 3'd3,
    OP_SLL  = 3'd4,
    OP_SRA  = 3'd5,
    OP_ROR  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RED1 = 2'd1,
    ST_RED2 = 2'd2
  } state_e;

  function automatic logic [DATA_W-1:0] sext8(input logic [7:0] v);
    return {{(DATA_W-8){v[7]}}, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_exec_stage_if : operand/op input and result output handshake bundle   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface alu_exec_stage_if;
  import alu_exec_stage_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [3:0]        imm;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic [2:0]        flags;

  modport master (
    output in_valid, op, a, b, imm, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, op, a, b, imm, out_ready,
    output in_ready, out_valid, result, flags
  );

endinterface
`default_nettype wire

// File: rtl/cla_16bit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cla_16bit : two-level carry-lookahead adder/subtractor, saturating output |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module cla_16bit (
  input  wire logic [15:0] a,
  input  wire logic [15:0] b,
  input  wire logic        sub,
  output logic      [15:0] sum,
  output logic             overflow
);

  localparam int GROUPS = 4;

  logic [15:0] w_b;
  logic [15:0] w_p;
  logic [15:0] w_g;
  logic [15:0] w_raw;
  logic [3:0]  w_grp_g;
  logic [3:0]  w_grp_p;
  logic [3:0]  w_grp_c;

  assign w_b = b ^ {16{sub}};
  assign w_p = a ^ w_b;
  assign w_g = a & w_b;

  genvar gi;
  generate
    for (gi = 0; gi < GROUPS; gi++) begin : g_grp
      logic [3:0] w_gp;
      logic [3:0] w_gg;
      logic [3:0] w_c;
      logic       w_cin;

      assign w_gp  = w_p[4*gi +: 4];
      assign w_gg  = w_g[4*gi +: 4];
      assign w_cin = w_grp_c[gi];

      assign w_c[0] = w_cin;
      assign w_c[1] = w_gg[0] | (w_gp[0] & w_cin);
      assign w_c[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & w_cin);
      assign w_c[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                    | (w_gp[2] & w_gp[1] & w_gp[0] & w_cin);

      assign w_grp_g[gi] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                         | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0]);
      assign w_grp_p[gi] = &w_gp;

      assign w_raw[4*gi +: 4] = w_gp ^ w_c;
    end
  endgenerate

  // Group carries are fully expanded so no carry depends on another carry net.
  assign w_grp_c[0] = sub;
  assign w_grp_c[1] = w_grp_g[0] | (w_grp_p[0] & sub);
  assign w_grp_c[2] = w_grp_g[1] | (w_grp_p[1] & w_grp_g[0]) | (w_grp_p[1] & w_grp_p[0] & sub);
  assign w_grp_c[3] = w_grp_g[2] | (w_grp_p[2] & w_grp_g[1])
                    | (w_grp_p[2] & w_grp_p[1] & w_grp_g[0])
                    | (w_grp_p[2] & w_grp_p[1] & w_grp_p[0] & sub);

  assign overflow = (a[15] == w_b[15]) && (w_raw[15] != a[15]);
  assign sum      = overflow ? (a[15] ? 16'h8000 : 16'h7FFF) : w_raw;

endmodule
`default_nettype wire

// File: rtl/alu_exec_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_exec_stage : registered execute stage with Z/V/N flags and 3-cycle RED |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int         WIDTH    = 16,
  parameter logic [2:0] FLAG_RST = 3'b000
) (
  input wire logic           clk,
  input wire logic           rst_n,
  alu_exec_stage_if.slave    bus
);

  state_e           r_state;
  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [7:0]       r_a_lo;
  logic [7:0]       r_b_lo;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [2:0]       r_flags;

  op_e              w_op;
  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_add_x;
  logic [WIDTH-1:0] w_add_y;
  logic             w_add_sub;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;
  logic [WIDTH-1:0] w_sll;
  logic [WIDTH-1:0] w_sra;
  logic [WIDTH-1:0] w_ror;
  logic [WIDTH-1:0] w_single;
  logic             w_arith;

  assign w_op       = op_e'(bus.op);
  assign w_in_ready = (r_state == ST_IDLE) && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_arith    = (w_op == OP_ADD) || (w_op == OP_SUB);

  // The single adder is time-shared: live operands, then low bytes, then partial sums.
  always_comb begin
    w_add_x   = bus.a;
    w_add_y   = bus.b;
    w_add_sub = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_op == OP_RED) begin
          w_add_x = sext8(bus.a[15:8]);
          w_add_y = sext8(bus.b[15:8]);
        end else begin
          w_add_sub = (w_op == OP_SUB);
        end
      end
      ST_RED1: begin
        w_add_x = sext8(r_a_lo);
        w_add_y = sext8(r_b_lo);
      end
      ST_RED2: begin
        w_add_x = r_s1;
        w_add_y = r_s2;
      end
      default: ;
    endcase
  end

  cla_16bit u_cla (
    .a        (w_add_x),
    .b        (w_add_y),
    .sub      (w_add_sub),
    .sum      (w_sum),
    .overflow (w_ovf)
  );

  assign w_sll = bus.a << bus.imm;
  assign w_sra = $signed(bus.a) >>> bus.imm;
  assign w_ror = (bus.a >> bus.imm) | (bus.a << (5'd16 - {1'b0, bus.imm}));

  always_comb begin
    w_single = bus.a ^ bus.b;
    case (w_op)
      OP_ADD, OP_SUB: w_single = w_sum;
      OP_SLL:         w_single = w_sll;
      OP_SRA:         w_single = w_sra;
      OP_ROR:         w_single = w_ror;
      default:        w_single = bus.a ^ bus.b;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_s1        <= '0;
      r_s2        <= '0;
      r_a_lo      <= '0;
      r_b_lo      <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= FLAG_RST;
    end else begin
      if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_op == OP_RED) begin
              r_s1    <= w_sum;
              r_a_lo  <= bus.a[7:0];
              r_b_lo  <= bus.b[7:0];
              r_state <= ST_RED1;
            end else begin
              r_result        <= w_single;
              r_out_valid     <= 1'b1;
              r_flags[FLAG_Z] <= (w_single == '0);
              if (w_arith) begin
                r_flags[FLAG_V] <= w_ovf;
                r_flags[FLAG_N] <= w_single[WIDTH-1];
              end
            end
          end
        end
        ST_RED1: begin
          r_s2    <= w_sum;
          r_state <= ST_RED2;
        end
        ST_RED2: begin
          // Entry to RED1 required an empty or retiring output, so the register is free here.
          r_result        <= w_sum;
          r_out_valid     <= 1'b1;
          r_flags[FLAG_Z] <= (w_sum == '0);
          r_state         <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.flags     = r_flags;

endmodule
`default_nettype wire
